// File: rtl/gauss_stream_ctrl.sv
`default_nettype none
// ============================================================================
// gauss_stream_ctrl : frame sequencer and AXI-Stream wrapper around the
//                     streaming 3x3 Gaussian convolution datapath
// Rev 1.0
// ============================================================================
module gauss_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = INPUT_WIDTH*PIXELS_PER_BEAT,
  parameter int PIPE_LAT        = 2,
  parameter int SKIP_BEATS      = IMAGE_DIM/PIXELS_PER_BEAT,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  conv_aresetn,
  output logic                  conv_stall,
  output logic [DATA_WIDTH-1:0] conv_inp,
  input  logic [DATA_WIDTH-1:0] conv_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_tlast
);

  localparam int N_BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT;
  localparam int IN_W    = $clog2(N_BEATS+SKIP_BEATS);
  localparam int OUT_W   = $clog2(N_BEATS);
  localparam int DR_W    = $clog2(PIPE_LAT+1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

  localparam logic [IN_W-1:0]  IN_LAST    = IN_W'(N_BEATS-1);
  localparam logic [IN_W-1:0]  FLUSH_LAST = IN_W'(N_BEATS+SKIP_BEATS-1);
  localparam logic [IN_W-1:0]  SKIP_IDX   = IN_W'(SKIP_BEATS);
  localparam logic [OUT_W-1:0] OUT_LAST   = OUT_W'(N_BEATS-1);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(PIPE_LAT-1);
  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   NEED_FREE  = (CNT_W+1)'(PIPE_LAT+1);

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [IN_W-1:0]        in_cnt;
  logic [DR_W-1:0]        drain_cnt;
  logic [PIPE_LAT-1:0]    tag_sr;
  logic [PIPE_LAT:0]      tag_shift;
  logic                   tag_in;
  logic                   advance;
  logic                   push, pop, s_hs;
  logic                   space_ok;
  logic [CNT_W:0]         free_slots;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [OUT_W-1:0]       out_cnt;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

  // A slot freed by this cycle's pop may be reused by this cycle's advance.
  assign pop        = m_tvalid & m_tready;
  assign free_slots = DEPTH_C - {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, pop};
  assign space_ok   = (free_slots >= NEED_FREE);

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    s_tready  = 1'b0;
    tag_in    = 1'b0;
    case (state)
      ST_CLR: state_nxt = ST_RUN;
      ST_RUN: begin
        s_tready = space_ok;
        advance  = s_tvalid & space_ok;
        tag_in   = (in_cnt >= SKIP_IDX);
        if (advance && in_cnt == IN_LAST) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        advance = space_ok;
        tag_in  = (in_cnt >= SKIP_IDX);
        if (advance && in_cnt == FLUSH_LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        advance = space_ok;
        if (advance && drain_cnt == DRAIN_LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifo_cnt == '0) state_nxt = ST_CLR;
      end
      default: state_nxt = ST_CLR;
    endcase
  end

  assign s_hs         = s_tvalid & s_tready;
  assign conv_stall   = ~advance;
  assign conv_inp     = (state == ST_RUN) ? s_tdata : '0;
  assign conv_aresetn = (state != ST_CLR);
  assign busy         = (state != ST_CLR);
  assign tag_shift    = {tag_sr, tag_in};
  assign push         = advance & tag_sr[PIPE_LAT-1];

  assign m_tvalid   = (fifo_cnt != '0);
  assign m_tdata    = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tlast    = m_tvalid && (out_cnt == OUT_LAST);
  assign frame_done = pop & m_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLR;
      in_cnt    <= '0;
      drain_cnt <= '0;
      tag_sr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      out_cnt   <= '0;
      err_tlast <= 1'b0;
    end else begin
      state <= state_nxt;
      // Clearing in CLR realigns the warm-up tagging with the freshly reset datapath.
      if (state == ST_CLR) begin
        in_cnt    <= '0;
        drain_cnt <= '0;
        tag_sr    <= '0;
      end else if (advance) begin
        tag_sr <= tag_shift[PIPE_LAT-1:0];
        if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        else                   in_cnt    <= in_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pop) out_cnt <= m_tlast ? '0 : out_cnt + 1'b1;
      if (s_hs && ((in_cnt == IN_LAST) ? !s_tlast : s_tlast)) err_tlast <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= conv_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_gauss_stream_ctrl.sv
`default_nettype none
// Randomized frames through a stand-in datapath; outputs are checked against
// a frame-level model that derives each output row from the input image.
module tb_gauss_stream_ctrl;

  localparam int PPB   = 16;
  localparam int IW    = 8;
  localparam int DIM   = 32;
  localparam int DW    = IW*PPB;
  localparam int PL    = 2;
  localparam int SKIP  = DIM/PPB;
  localparam int DEPTH = 8;
  localparam int N     = DIM*DIM/PPB;
  localparam int ADV   = N+SKIP+PL;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic          conv_aresetn, conv_stall;
  logic [DW-1:0] conv_inp, conv_out;
  logic          busy, frame_done, err_tlast;

  always #5 clk = ~clk;

  gauss_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB), .INPUT_WIDTH(IW), .IMAGE_DIM(DIM),
    .DATA_WIDTH(DW), .PIPE_LAT(PL), .SKIP_BEATS(SKIP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .conv_aresetn(conv_aresetn), .conv_stall(conv_stall),
    .conv_inp(conv_inp), .conv_out(conv_out),
    .busy(busy), .frame_done(frame_done), .err_tlast(err_tlast)
  );

  // Stand-in datapath: output = row-delayed current beat XOR (beat one row above << 1).
  logic [DW-1:0] dp_hist [SKIP+PL];
  always @(posedge clk) begin
    if (!conv_aresetn) begin
      for (int i = 0; i < SKIP+PL; i++) dp_hist[i] <= '0;
    end else if (!conv_stall) begin
      dp_hist[0] <= conv_inp;
      for (int i = 1; i < SKIP+PL; i++) dp_hist[i] <= dp_hist[i-1];
    end
  end
  assign conv_out = dp_hist[PL-1] ^ (dp_hist[PL+SKIP-1] << 1);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] frame_data [N];
  logic [DW-1:0] exp_q [$];
  int            ready_mode = 0;
  int            rdy_ph     = 0;

  // Output j of a frame is image row-position j+SKIP (zero past the end) combined with position j.
  task automatic gen_frame(input bit fresh);
    logic [DW-1:0] cur;
    if (fresh)
      for (int i = 0; i < N; i++) frame_data[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < N; j++) begin
      cur = (j+SKIP < N) ? frame_data[j+SKIP] : '0;
      exp_q.push_back(cur ^ (frame_data[j] << 1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_tready"},     DW'(s_tready),     '0);
    chk({tag, "_m_tvalid"},     DW'(m_tvalid),     '0);
    chk({tag, "_m_tlast"},      DW'(m_tlast),      '0);
    chk({tag, "_m_tdata"},      m_tdata,           '0);
    chk({tag, "_conv_stall"},   DW'(conv_stall),   DW'(1));
    chk({tag, "_conv_aresetn"}, DW'(conv_aresetn), '0);
    chk({tag, "_busy"},         DW'(busy),         '0);
    chk({tag, "_frame_done"},   DW'(frame_done),   '0);
    chk({tag, "_err_tlast"},    DW'(err_tlast),    '0);
  endtask

  task automatic send_frame(input int gap_pct, input bit bad_last, input int abort_at);
    int  cyc;
    bit  got;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("abort");
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = frame_data[i];
      s_tlast  = bad_last ? (i == 10) : (i == N-1);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 2000) begin
        @(negedge clk);
        if (s_tready) got = 1'b1;
        cyc++;
      end
      if (!got) begin
        chk("s_handshake_timeout", DW'(0), DW'(1));
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", DW'(exp_q.size()), '0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: begin
          rdy_ph   = (rdy_ph == 2) ? 0 : rdy_ph + 1;
          m_tready = (rdy_ph == 0);
        end
        default: m_tready = ($urandom_range(99) < 60);
      endcase
    end
  end

  // Monitor: everything sampled on the falling edge, away from the active edge.
  int            out_idx = 0, in_idx = 0, stall_cnt = 0, clr_cnt = 0, done_cnt = 0;
  bit            err_model = 1'b0, prev_hold = 1'b0, hs_in, hs_out;
  logic [DW-1:0] held_data;

  always @(negedge clk) begin
    if (rst) begin
      out_idx = 0; in_idx = 0; stall_cnt = 0; clr_cnt = 0;
      err_model = 1'b0; prev_hold = 1'b0;
      exp_q.delete();
    end else begin
      hs_out = m_tvalid && m_tready;
      hs_in  = s_tvalid && s_tready;
      if (prev_hold) begin
        chk("hold_valid", DW'(m_tvalid), DW'(1));
        chk("hold_data", m_tdata, held_data);
      end
      prev_hold = m_tvalid && !m_tready;
      held_data = m_tdata;
      chk("frame_done", DW'(frame_done), DW'(hs_out && out_idx == N-1));
      if (hs_out) begin
        if (exp_q.size() == 0) chk("unexpected_output", m_tdata, '0);
        else chk("m_tdata", m_tdata, exp_q.pop_front());
        chk("m_tlast", DW'(m_tlast), DW'(out_idx == N-1));
        out_idx = (out_idx == N-1) ? 0 : out_idx + 1;
      end
      if (!conv_stall) stall_cnt++;
      if (frame_done) begin
        chk("advance_cycles", DW'(stall_cnt), DW'(ADV));
        stall_cnt = 0;
        clr_cnt   = 0;
        done_cnt++;
      end
      if (!conv_aresetn) clr_cnt++;
      if (in_idx != 0) chk("stall_vs_handshake", DW'(conv_stall), DW'(!hs_in));
      chk("err_tlast", DW'(err_tlast), DW'(err_model));
      if (hs_in) begin
        if (in_idx == 0) chk("clr_pulse_len", DW'(clr_cnt), DW'(1));
        if ((in_idx == N-1) ? !s_tlast : s_tlast) err_model = 1'b1;
        in_idx = (in_idx == N-1) ? 0 : in_idx + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    chk("clr_aresetn", DW'(conv_aresetn), '0);
    chk("clr_busy", DW'(busy), '0);
    @(posedge clk); #1;
    chk("run_busy", DW'(busy), DW'(1));
    chk("run_aresetn", DW'(conv_aresetn), DW'(1));

    // Continuous flow
    ready_mode = 0;
    gen_frame(1'b1); send_frame(0, 1'b0, -1); wait_idle();
    chk("err_after_clean", DW'(err_tlast), '0);

    // Same image under 1-of-3 back-pressure
    ready_mode = 1;
    gen_frame(1'b0); send_frame(0, 1'b0, -1); wait_idle();

    // Random input gaps
    ready_mode = 0;
    gen_frame(1'b1); send_frame(50, 1'b0, -1); wait_idle();

    // Misplaced s_tlast
    gen_frame(1'b1); send_frame(0, 1'b1, -1); wait_idle();
    chk("err_sticky", DW'(err_tlast), DW'(1));

    // Two frames back-to-back with random back-pressure
    ready_mode = 2;
    gen_frame(1'b1); send_frame(0, 1'b0, -1);
    gen_frame(1'b1); send_frame(0, 1'b0, -1); wait_idle();
    chk("err_still_set", DW'(err_tlast), DW'(1));

    // Abort at beat 30, then a full frame
    ready_mode = 0;
    gen_frame(1'b1); send_frame(0, 1'b0, 30);
    gen_frame(1'b1); send_frame(0, 1'b0, -1); wait_idle();

    chk("frame_done_total", DW'(done_cnt), DW'(7));
    chk("queue_empty", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
